// File: rtl/moore_seq_pkg.sv
// moore_seq_pkg -- shared constants for the Moore sequence detector.
//   PAT_W_MIN / PAT_W_MAX : legal range of the pattern length parameter
//   mode_e                : match mode encoding (non-overlapping / overlapping)
package moore_seq_pkg;

  localparam int PAT_W_MIN = 2;
  localparam int PAT_W_MAX = 16;

  typedef enum logic {
    MODE_NONOVL = 1'b0,
    MODE_OVL    = 1'b1
  } mode_e;

endpackage

// File: rtl/seq_sat_counter.sv
// seq_sat_counter -- counter that increments by one per request and sticks
// at its all-ones value.
//   clk_i  : clock, rising edge
//   rst_ni : asynchronous active-low reset, clears the count
//   inc_i  : increment request for this cycle
//   cnt_o  : current count (registered)
module seq_sat_counter #(
  parameter int CNT_W = 8
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             inc_i,
  output logic [CNT_W-1:0] cnt_o
);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (inc_i && (cnt_q != {CNT_W{1'b1}})) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt_o = cnt_q;

endmodule

// File: rtl/moore_seq_detector.sv
// moore_seq_detector -- serial bit-pattern detector with a registered (Moore)
// match flag, runtime-loadable pattern and overlapping/non-overlapping mode.
//   clk         : clock, rising edge
//   rst         : asynchronous active-low reset
//   cfg_load    : capture cfg_pattern / cfg_overlap this cycle (beats in_valid)
//   cfg_pattern : pattern, MSB is the first bit received
//   cfg_overlap : 1 = overlapping matches, 0 = non-overlapping
//   in_valid    : qualifies the serial input bit
//   in          : serial data bit
//   out         : match flag, high for one cycle after the completing bit
//   match_cnt   : saturating match count, only when MOORE_SEQ_MATCH_CNT_EN
//                 is defined
// Optional feature macro: MOORE_SEQ_MATCH_CNT_EN.
module moore_seq_detector
  import moore_seq_pkg::*;
#(
  parameter int PAT_W = 4,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cfg_load,
  input  logic [PAT_W-1:0] cfg_pattern,
  input  logic             cfg_overlap,
  input  logic             in_valid,
  input  logic             in,
  output logic             out
`ifdef MOORE_SEQ_MATCH_CNT_EN
  ,
  output logic [CNT_W-1:0] match_cnt
`endif
);

  if (PAT_W < PAT_W_MIN || PAT_W > PAT_W_MAX) begin : g_pat_w_check
    $error("moore_seq_detector: PAT_W=%0d outside %0d..%0d",
           PAT_W, PAT_W_MIN, PAT_W_MAX);
  end

  localparam int FILL_W = $clog2(PAT_W + 1);
  localparam logic [FILL_W-1:0] FILL_FULL = FILL_W'(PAT_W);

  logic [PAT_W-1:0]  hist_q, hist_d;
  logic [FILL_W-1:0] fill_q, fill_d;
  logic [PAT_W-1:0]  pat_q,  pat_d;
  mode_e             mode_q, mode_d;
  logic              out_q,  out_d;

  logic [PAT_W-1:0]  hist_shift;
  logic [FILL_W-1:0] fill_inc;

  // State register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      hist_q <= '0;
      fill_q <= '0;
      pat_q  <= '0;
      mode_q <= MODE_OVL;
      out_q  <= 1'b0;
    end else begin
      hist_q <= hist_d;
      fill_q <= fill_d;
      pat_q  <= pat_d;
      mode_q <= mode_d;
      out_q  <= out_d;
    end
  end

  // Next-state logic. The match decision looks at the post-shift history so
  // the flag registered on this edge reflects the bit just sampled.
  always_comb begin
    hist_shift = {hist_q[PAT_W-2:0], in};
    fill_inc   = (fill_q == FILL_FULL) ? fill_q : fill_q + 1'b1;

    hist_d = hist_q;
    fill_d = fill_q;
    pat_d  = pat_q;
    mode_d = mode_q;
    out_d  = 1'b0;

    if (cfg_load) begin
      // A simultaneous input bit is dropped: the new pattern starts clean.
      pat_d  = cfg_pattern;
      mode_d = mode_e'(cfg_overlap);
      fill_d = '0;
    end else if (in_valid) begin
      hist_d = hist_shift;
      fill_d = fill_inc;
      out_d  = (hist_shift == pat_q) && (fill_inc == FILL_FULL);
      // Non-overlapping: the next match needs PAT_W new bits; the stale
      // history is masked by the fill counter, so it need not be cleared.
      if (out_d && (mode_q == MODE_NONOVL)) begin
        fill_d = '0;
      end
    end
  end

  // Output logic: the flag comes straight from state.
  always_comb begin
    out = out_q;
  end

`ifdef MOORE_SEQ_MATCH_CNT_EN
  seq_sat_counter #(
    .CNT_W (CNT_W)
  ) u_match_cnt (
    .clk_i  (clk),
    .rst_ni (rst),
    .inc_i  (out_d),
    .cnt_o  (match_cnt)
  );
`endif

endmodule
